picorv32_ddr3_avl_bridge: RTL

Upstream master for the DDR3 Qsys controller. Converts picorv32 native memory transactions (valid/ready) into Avalon-MM bursts on the controller's 32-bit avl port. Holds a single 4-word line buffer, so sequential instruction and data reads hit without a DDR3 round trip. Writes are write-through and single-beat. Sits between the SoC address decoder (DDR window select) and the controller; runs on the controller's afi_clk domain.

---
 rtl/picorv32_ddr3_avl_bridge.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/picorv32_ddr3_avl_bridge.sv
// picorv32 native-bus to DDR3 Avalon-MM bridge with a single write-through line buffer.
// Read misses fill a whole line with one burst; writes are single-beat and merge into a buffered line.
module picorv32_ddr3_avl_bridge #(
    parameter int AVL_ADDR_W = 21,
    parameter int BURST_LEN  = 4,
    parameter int LINEBUF_EN = 1
) (
    input  logic                  clk_i,
    input  logic                  resetn_i,
    input  logic                  mem_valid_i,
    input  logic [31:0]           mem_addr_i,
    input  logic [31:0]           mem_wdata_i,
    input  logic [3:0]            mem_wstrb_i,
    output logic                  mem_ready_o,
    output logic [31:0]           mem_rdata_o,
    output logic [AVL_ADDR_W-1:0] avl_address_o,
    output logic                  avl_read_o,
    output logic                  avl_write_o,
    output logic [31:0]           avl_writedata_o,
    output logic [3:0]            avl_byteenable_o,
    output logic [2:0]            avl_burstcount_o,
    output logic                  avl_beginbursttransfer_o,
    input  logic                  avl_waitrequest_n_i,
    input  logic                  avl_readdatavalid_i,
    input  logic [31:0]           avl_readdata_i,
    input  logic                  local_init_done_i,
    input  logic                  local_cal_fail_i,
    output logic                  ddr_err_o,
    output logic [2:0]            dbg_state_o
);

    localparam int BEAT_W     = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam int LINE_WORDS = 1 << BEAT_W;
    localparam logic [AVL_ADDR_W-1:0] OFF_MASK  = AVL_ADDR_W'(BURST_LEN - 1);
    localparam logic [BEAT_W-1:0]     LAST_BEAT = BEAT_W'(BURST_LEN - 1);
    localparam logic [2:0]            BURST_CNT = 3'(BURST_LEN);

    // Avalon handshake: a command (read or write) is held unchanged from its first cycle
    // until avl_waitrequest_n_i=1, and is accepted on that rising edge. Upstream, mem_valid_i
    // is held by the CPU until mem_ready_o pulses for one cycle.
    typedef enum logic [2:0] {
        S_INIT_WAIT = 3'd0,
        S_IDLE      = 3'd1,
        S_RD_REQ    = 3'd2,
        S_RD_DATA   = 3'd3,
        S_WR_REQ    = 3'd4,
        S_RESP      = 3'd5
    } state_t;

    state_t                  state_q;
    logic                    valid_q;
    logic [AVL_ADDR_W-1:0]   tag_q;
    logic [31:0]             line_q [LINE_WORDS];
    logic [BEAT_W-1:0]       beat_q;
    logic [AVL_ADDR_W-1:0]   req_waddr_q;
    logic                    mem_ready_q;
    logic [31:0]             mem_rdata_q;
    logic [AVL_ADDR_W-1:0]   avl_address_q;
    logic                    avl_read_q;
    logic                    avl_write_q;
    logic [31:0]             avl_writedata_q;
    logic [3:0]              avl_byteenable_q;
    logic [2:0]              avl_burstcount_q;
    logic                    avl_begin_q;
    logic                    ddr_err_q;

    logic [AVL_ADDR_W-1:0]   waddr_d;
    logic [AVL_ADDR_W-1:0]   line_addr_d;
    logic [BEAT_W-1:0]       widx_d;
    logic                    hit_d;
    logic [AVL_ADDR_W-1:0]   req_line;
    logic [BEAT_W-1:0]       req_idx;
    logic                    unused_addr_bits;

    // The tag is kept as the full line-aligned word address, which compares the same bits
    // as the upper-address tag while reusing the burst address directly.
    assign waddr_d     = mem_addr_i[AVL_ADDR_W+1:2];
    assign line_addr_d = waddr_d & ~OFF_MASK;
    assign widx_d      = BEAT_W'(waddr_d & OFF_MASK);
    assign hit_d       = (LINEBUF_EN != 0) && valid_q && (tag_q == line_addr_d);
    assign req_line    = req_waddr_q & ~OFF_MASK;
    assign req_idx     = BEAT_W'(req_waddr_q & OFF_MASK);
    assign unused_addr_bits = ^{mem_addr_i[31:AVL_ADDR_W+2], mem_addr_i[1:0]};

    always_ff @(posedge clk_i) begin
        if (!resetn_i) begin
            state_q          <= S_INIT_WAIT;
            valid_q          <= 1'b0;
            tag_q            <= '0;
            beat_q           <= '0;
            req_waddr_q      <= '0;
            mem_ready_q      <= 1'b0;
            mem_rdata_q      <= '0;
            avl_address_q    <= '0;
            avl_read_q       <= 1'b0;
            avl_write_q      <= 1'b0;
            avl_writedata_q  <= '0;
            avl_byteenable_q <= '0;
            avl_burstcount_q <= '0;
            avl_begin_q      <= 1'b0;
            ddr_err_q        <= 1'b0;
        end else begin
            mem_ready_q <= 1'b0;
            case (state_q)
                S_INIT_WAIT: begin
                    if (local_cal_fail_i) begin
                        ddr_err_q <= 1'b1;
                    end else if (local_init_done_i) begin
                        state_q <= S_IDLE;
                    end
                end
                S_IDLE: begin
                    if (mem_valid_i) begin
                        req_waddr_q <= waddr_d;
                        if (mem_wstrb_i != 4'b0000) begin
                            avl_write_q      <= 1'b1;
                            avl_address_q    <= waddr_d;
                            avl_writedata_q  <= mem_wdata_i;
                            avl_byteenable_q <= mem_wstrb_i;
                            avl_burstcount_q <= 3'd1;
                            avl_begin_q      <= 1'b1;
                            state_q          <= S_WR_REQ;
                        end else if (hit_d) begin
                            mem_ready_q <= 1'b1;
                            mem_rdata_q <= line_q[widx_d];
                            state_q     <= S_RESP;
                        end else begin
                            avl_read_q       <= 1'b1;
                            avl_address_q    <= line_addr_d;
                            avl_byteenable_q <= 4'hF;
                            avl_burstcount_q <= BURST_CNT;
                            avl_begin_q      <= 1'b1;
                            state_q          <= S_RD_REQ;
                        end
                    end
                end
                S_RD_REQ: begin
                    avl_begin_q <= 1'b0;
                    if (avl_waitrequest_n_i) begin
                        avl_read_q       <= 1'b0;
                        avl_byteenable_q <= '0;
                        avl_burstcount_q <= '0;
                        beat_q           <= '0;
                        state_q          <= S_RD_DATA;
                    end
                end
                S_RD_DATA: begin
                    if (avl_readdatavalid_i) begin
                        line_q[beat_q] <= avl_readdata_i;
                        beat_q         <= beat_q + BEAT_W'(1);
                        if (beat_q == LAST_BEAT) begin
                            tag_q       <= req_line;
                            valid_q     <= 1'b1;
                            mem_ready_q <= 1'b1;
                            mem_rdata_q <= (req_idx == beat_q) ? avl_readdata_i : line_q[req_idx];
                            state_q     <= S_RESP;
                        end
                    end
                end
                S_WR_REQ: begin
                    avl_begin_q <= 1'b0;
                    if (avl_waitrequest_n_i) begin
                        // Keep the buffered copy coherent with what DDR now holds.
                        if (valid_q && (tag_q == req_line)) begin
                            for (int b = 0; b < 4; b++) begin
                                if (avl_byteenable_q[b]) begin
                                    line_q[req_idx][8*b +: 8] <= avl_writedata_q[8*b +: 8];
                                end
                            end
                        end
                        avl_write_q      <= 1'b0;
                        avl_byteenable_q <= '0;
                        avl_burstcount_q <= '0;
                        mem_ready_q      <= 1'b1;
                        mem_rdata_q      <= '0;
                        state_q          <= S_RESP;
                    end
                end
                S_RESP: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_INIT_WAIT;
                end
            endcase
        end
    end

    assign mem_ready_o              = mem_ready_q;
    assign mem_rdata_o              = mem_rdata_q;
    assign avl_address_o            = avl_address_q;
    assign avl_read_o               = avl_read_q;
    assign avl_write_o              = avl_write_q;
    assign avl_writedata_o          = avl_writedata_q;
    assign avl_byteenable_o         = avl_byteenable_q;
    assign avl_burstcount_o         = avl_burstcount_q;
    assign avl_beginbursttransfer_o = avl_begin_q;
    assign ddr_err_o                = ddr_err_q;
    assign dbg_state_o              = state_q;

endmodule
